muldiv_seq: RTL

//   Iterative RV32M multiply/divide sequencer beside the single-cycle ALU. The controller hands off funct7=0x01 ops.

---
 rtl/muldiv_seq.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: special cases (div by zero, signed overflow, zero multiply) skip CALC.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high unless flushing
  // CALC  | one multiply/divide iteration per edge, XLEN edges
  // FIX   | sign correction, field select, special-case override
  // DONE  | result held on rsp_* until rsp_ready
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CW = $clog2(XLEN);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [XLEN:0]     hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   spec_val_q, spec_val_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              accept;
  logic              a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, mul_zero, spec_in;
  logic [XLEN-1:0]   spec_val_in;
  logic [XLEN:0]     mul_sum, div_rsh, div_diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  assign accept = req_valid && req_ready;

  // Request decode: operand magnitudes, result sign and special-case detection.
  always_comb begin
    a_signed    = (req_funct3 == 3'd1) || (req_funct3 == 3'd2) ||
                  (req_funct3 == 3'd4) || (req_funct3 == 3'd6);
    b_signed    = (req_funct3 == 3'd1) || (req_funct3 == 3'd4) || (req_funct3 == 3'd6);
    sign_a      = a_signed && req_rs1[XLEN-1];
    sign_b      = b_signed && req_rs2[XLEN-1];
    mag_a       = sign_a ? (~req_rs1 + 1'b1) : req_rs1;
    mag_b       = sign_b ? (~req_rs2 + 1'b1) : req_rs2;
    div_zero    = (req_rs2 == '0);
    div_ovf     = ((req_funct3 == 3'd4) || (req_funct3 == 3'd6)) &&
                  (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_rs2 == '1);
    mul_zero    = (req_rs1 == '0) || (req_rs2 == '0);
    spec_in     = 1'b0;
    spec_val_in = '0;
    if (!req_funct3[2]) begin
      spec_in = mul_zero;
    end else if (div_zero) begin
      spec_in     = 1'b1;
      spec_val_in = req_funct3[1] ? req_rs1 : '1;
    end else if (div_ovf) begin
      spec_in     = 1'b1;
      spec_val_in = req_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // Iteration step and final correction.
  always_comb begin
    mul_sum  = {1'b0, hi_q[XLEN-1:0]} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_rsh  = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    div_diff = div_rsh - {1'b0, opb_q};
    prod     = {hi_q[XLEN-1:0], lo_q};
    prod_s   = neg_q ? (~prod + 1'b1) : prod;
    quo_s    = neg_q ? (~lo_q + 1'b1) : lo_q;
    rem_s    = neg_q ? (~hi_q[XLEN-1:0] + 1'b1) : hi_q[XLEN-1:0];
  end

  always_comb begin
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    tag_d      = tag_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opb_d      = opb_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    res_d      = res_q;
    if (accept) begin
      cnt_d      = '0;
      f3_d       = req_funct3;
      tag_d      = req_tag;
      hi_d       = '0;
      spec_d     = spec_in;
      spec_val_d = spec_val_in;
      if (!req_funct3[2]) begin
        lo_d  = mag_b;
        opb_d = mag_a;
        neg_d = sign_a ^ sign_b;
      end else begin
        lo_d  = mag_a;
        opb_d = mag_b;
        neg_d = req_funct3[1] ? sign_a : (sign_a ^ sign_b);
      end
    end else if (state_q == CALC) begin
      if (cnt_q != CW'(XLEN-1)) cnt_d = cnt_q + CW'(1);
      if (!f3_q[2]) begin
        hi_d = {1'b0, mul_sum[XLEN:1]};
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end else if (!div_diff[XLEN]) begin
        hi_d = div_diff;
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = div_rsh;
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else if (state_q == FIX) begin
      if (spec_q)                res_d = spec_val_q;
      else if (f3_q == 3'd0)     res_d = prod_s[XLEN-1:0];
      else if (!f3_q[2])         res_d = prod_s[2*XLEN-1:XLEN];
      else if (!f3_q[1])         res_d = quo_s;
      else                       res_d = rem_s;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
`ifdef MULDIV_EARLY_OUT_EN
          state_d = spec_in ? FIX : CALC;
`else
          state_d = CALC;
`endif
        end
        CALC: if (cnt_q == CW'(XLEN-1)) state_d = FIX;
        FIX:  state_d = DONE;
        DONE: if (rsp_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE) && !flush;
    rsp_valid  = (state_q == DONE);
    busy       = (state_q != IDLE);
    rsp_result = res_q;
    rsp_tag    = tag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      tag_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      tag_q      <= tag_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opb_q      <= opb_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      res_q      <= res_d;
    end
  end

endmodule
